entropy_streamer: RTL
=====================

// Module: entropy_streamer
// PURPOSE
// - Autonomous bus initiator: polls the entropy core over the 32-bit memory-like bus, reads
//   entropy words, serialises each as a framed byte stream on a syn/ack byte port to the UART tx.
// - Reverse direction of coretest (bytes->bus); lets the host sink raw entropy with no commands.
// - Sits between the address mux (as a bus master) and the uart txd_syn/txd_data/txd_ack port.
// PARAMETERS
// - ENT_PREFIX    8'h10  address[15:8] of the entropy core
// - STATUS_ADDR   8'h09  status reg; read_data[0] = word ready
// - DATA_ADDR     8'h20  entropy data reg; a read consumes the word
// - POLL_WAIT     16     idle cycles between unsuccessful status polls (>=1)
// - HDR_BYTE      8'hAA  frame header byte
// PORTS
// - clk            in   1   system clock
// - reset          in   1   async active-high reset
// - enable         in   1   level; 1 = stream, 0 = stop after current frame
// - word_limit     in   16  words per run; 0 = unlimited; sampled on leaving IDLE
// - bus_cs         out  1   bus select, one-cycle pulses
// - bus_we         out  1   always 0 (read-only master)
// - bus_address    out  16  {ENT_PREFIX, reg addr}
// - bus_write_data out  32  always 0
// - bus_read_data  in   32  combinational read data, valid in cs cycle
// - bus_error      in   1   combinational error, valid in cs cycle
// - tx_syn         out  1   byte valid to uart tx
// - tx_data        out  8   byte; stable while tx_syn = 1
// - tx_ack         in   1   uart accepted byte
// - busy           out  1   1 when state != IDLE
// - error_flag     out  1   sticky, set on bus_error; cleared only by reset
// - word_count     out  32  words fully transmitted since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
// - Clock/reset: single clk; reset is asynchronous and active-high, all flops cleared immediately.
// - Reset values: all outputs 0 (bus_cs, tx_syn, tx_data, busy, error_flag, word_count); state IDLE.
// - Bus rule: every access is a one-cycle cs pulse with we=0; read_data/error sampled that same cycle.
// - Between accesses cs=0, address=0.
// - FSM:
//   - IDLE: if enable, latch word_limit, clear run counter -> POLL.
//   - POLL: cs to STATUS_ADDR.
//     - bus_error -> ERR.
//     - bit0=1 -> READ.
//     - else -> WAIT.
//   - WAIT: count POLL_WAIT cycles -> POLL; if enable=0 -> IDLE.
//   - READ: cs to DATA_ADDR, latch read_data into word reg.
//     - bus_error -> ERR.
//     - else -> SEND, byte index 0 (header).
//   - SEND: tx_syn=1, tx_data = HDR_BYTE, then word[31:24], [23:16], [15:8], [7:0].
//     - Hold until tx_ack=1 sampled -> GAP.
//   - GAP: tx_syn=0 for >=1 cycle and until tx_ack=0.
//     - If bytes remain -> SEND with next index.
//     - After byte 4: word_count++, run counter++ -> DONE.
//   - DONE: if enable=0 or (limit!=0 and run counter==limit) -> IDLE; else -> POLL.
//   - ERR: set error_flag, no bytes sent for that word -> IDLE (same cycle count: 1).
// - Latency: ready status to first tx_syn = 2 cycles (POLL, READ, SEND asserts).
// - Frame: 5 bytes, MSB first; frame never interrupted by enable=0, only by reset.
// - tx_ack high while tx_syn=0 is ignored; tx_syn never re-asserts while tx_ack still high.
// - Simultaneous enable=0 and ready status in POLL: read and send that word, then IDLE.
// - word_count updates only after last-byte ack; reset mid-frame drops tx_syn and discards word.
// TESTING
// - Ready on first poll, read_data=32'hDEADBEEF, ack each byte after 3 cycles
//   -> bytes AA DE AD BE EF, word_count=1.
// - Status bit0=0 for 3 polls then 1 -> cs pulses to 0x1009 spaced POLL_WAIT+1 apart,
//   then one read to 0x1020.
// - word_limit=2, enable held, always ready -> exactly 10 bytes, busy falls, no further cs.
// - bus_error on data read -> error_flag=1, no tx_syn, back to IDLE, word_count unchanged.
// - enable dropped during byte 2 -> remaining 3 bytes sent, then IDLE with no new poll.
// - reset asserted while tx_syn=1 -> tx_syn=0 immediately; word_count force to 32'hFFFFFFFF
//   + one frame -> wraps to 0.

Source files
------------

// File: rtl/entropy_streamer.sv
// Polls the entropy core as a read-only bus master and streams each word as a framed 5-byte burst (AA, MSB..LSB).
// Latency: a ready status poll is followed by the data read next cycle and tx_syn on the cycle after.
// Backpressure: each byte is held until tx_ack, then tx_syn drops until tx_ack falls; a frame is never cut short by enable.
module entropy_streamer #(
  parameter logic [7:0] ENT_PREFIX  = 8'h10,
  parameter logic [7:0] STATUS_ADDR = 8'h09,
  parameter logic [7:0] DATA_ADDR   = 8'h20,
  parameter int         POLL_WAIT   = 16,
  parameter logic [7:0] HDR_BYTE    = 8'hAA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] word_limit,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [15:0] bus_address,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_error,
  output logic        tx_syn,
  output logic [7:0]  tx_data,
  input  logic        tx_ack,
  output logic        busy,
  output logic        error_flag,
  output logic [31:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POLL = 3'd1,
    S_WAIT = 3'd2,
    S_READ = 3'd3,
    S_SEND = 3'd4,
    S_GAP  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  // WAIT lasts exactly POLL_WAIT cycles, so consecutive polls are POLL_WAIT+1 apart
  localparam logic [15:0] WAIT_LAST = 16'(POLL_WAIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] limit_q;
  logic [15:0] run_cnt;
  logic [31:0] word_q;
  logic [2:0]  byte_idx;
  logic        error_flag_q;
  logic [31:0] word_count_q;
  logic        word_done;

  // last byte acknowledged and tx_ack released: the frame is complete
  assign word_done = (state == S_GAP) && !tx_ack && (byte_idx == 3'd4);

  assign busy           = (state != S_IDLE);
  assign bus_we         = 1'b0;
  assign bus_write_data = 32'h0;
  assign error_flag     = error_flag_q;
  assign word_count     = word_count_q;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enable) state_nxt = S_POLL;
      S_POLL: begin
        if (bus_error)             state_nxt = S_ERR;
        else if (bus_read_data[0]) state_nxt = S_READ;
        else                       state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!enable)                    state_nxt = S_IDLE;
        else if (wait_cnt == WAIT_LAST) state_nxt = S_POLL;
      end
      S_READ: state_nxt = bus_error ? S_ERR : S_SEND;
      S_SEND: if (tx_ack) state_nxt = S_GAP;
      S_GAP: begin
        if (!tx_ack) state_nxt = (byte_idx == 3'd4) ? S_DONE : S_SEND;
      end
      S_DONE: begin
        if (!enable || ((limit_q != 16'd0) && (run_cnt == limit_q))) state_nxt = S_IDLE;
        else                                                          state_nxt = S_POLL;
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // bus strobes and byte port driven purely from the current state
  always_comb begin
    bus_cs      = 1'b0;
    bus_address = 16'h0;
    tx_syn      = 1'b0;
    tx_data     = 8'h0;
    case (state)
      S_POLL: begin
        bus_cs      = 1'b1;
        bus_address = {ENT_PREFIX, STATUS_ADDR};
      end
      S_READ: begin
        bus_cs      = 1'b1;
        bus_address = {ENT_PREFIX, DATA_ADDR};
      end
      S_SEND: begin
        tx_syn = 1'b1;
        case (byte_idx)
          3'd0:    tx_data = HDR_BYTE;
          3'd1:    tx_data = word_q[31:24];
          3'd2:    tx_data = word_q[23:16];
          3'd3:    tx_data = word_q[15:8];
          default: tx_data = word_q[7:0];
        endcase
      end
      default: ;
    endcase
  end

  // run bookkeeping, poll spacing, captured word, byte index and status counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt     <= 16'h0;
      limit_q      <= 16'h0;
      run_cnt      <= 16'h0;
      word_q       <= 32'h0;
      byte_idx     <= 3'd0;
      error_flag_q <= 1'b0;
      word_count_q <= 32'h0;
    end else begin
      word_count_q <= word_count_q + {31'd0, word_done};

      if ((state == S_IDLE) && enable) begin
        limit_q <= word_limit;
        run_cnt <= 16'h0;
      end else if (word_done) begin
        run_cnt <= run_cnt + 16'd1;
      end

      if (state == S_POLL)      wait_cnt <= 16'h0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;

      if (state == S_READ) begin
        word_q   <= bus_read_data;
        byte_idx <= 3'd0;
      end else if ((state == S_GAP) && !tx_ack && (byte_idx != 3'd4)) begin
        byte_idx <= byte_idx + 3'd1;
      end

      if (state == S_ERR) error_flag_q <= 1'b1;
    end
  end

endmodule
